uart_core: RTL
==============

Name: uart_core

Overview:
- Parametrised full-duplex UART. Successor to the fixed 8N1 transmit-only UART in the peripheral subsystem.
- Adds a programmable frame format (data bits, parity, stop bits) and a baud rate derived from parameters.
- Adds a 16x-oversampled receiver with error detection, plus TX and RX FIFOs, so the CPU peripheral bus can burst bytes without polling per bit.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, bits per character; legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- TX_DEPTH_LOG2, 3, TX FIFO depth is 2^N entries.
- RX_DEPTH_LOG2, 3, RX FIFO depth is 2^N entries.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- din  in  DATA_BITS  transmit byte.
- wr_en  in  1  push din into the TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  high while the TX FIFO is non-empty or a frame is in flight.
- rx  in  1  serial input; asynchronous to clk.
- dout  out  DATA_BITS  RX FIFO head, first-word-fall-through.
- rdy  out  1  RX FIFO non-empty.
- rd_en  in  1  pop the RX FIFO head.
- err_clr  in  1  clear the sticky error flags.
- parity_err  out  1  sticky: a received character had bad parity.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun_err  out  1  sticky: RX FIFO was full when a character completed, or wr_en was asserted while tx_full.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Both FIFOs emptied; both FSMs go to IDLE; divider cleared; synchroniser loaded with 1s.
  - Output values: tx=1, tx_busy=0, tx_full=0, rdy=0, dout=0, all error flags 0.
  - Reset mid-frame aborts the frame immediately; tx returns high the next cycle.
- Baud tick:
  - DIV = (CLK_HZ + 8*BAUD) / (16*BAUD), i.e. rounded. Integer divide at elaboration; DIV must be >= 2.
  - A counter produces a one-cycle tick16 every DIV clocks.
  - A bit period is 16 tick16 pulses.
- TX FIFO:
  - wr_en && !tx_full pushes din.
  - wr_en && tx_full drops the data and sets overrun_err.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: when the FIFO is not empty, pop the head into the shift register and go to START, aligned to the next tick16.
  - Each state holds for 16 tick16 pulses.
  - Line values: START drives 0; DATA shifts LSB first for DATA_BITS bits; PARITY drives the XOR of the data bits, inverted for odd parity; STOP drives 1 for STOP_BITS bit periods.
  - Back-to-back frames have no extra idle gap.
  - tx is driven from a register; no combinational glitches.
- RX front end:
  - Two-flop synchroniser on rx, then the FSM samples on tick16.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a low sample moves to START with the tick counter cleared.
  - START: re-sample at tick 7, i.e. the bit centre. If the line is high, it was a false start; return to IDLE with no flags set.
  - DATA: sample each bit at 16 ticks after the previous centre, LSB first.
  - PARITY: sample and compare against the computed parity.
  - STOP: only the first stop bit is checked.
- RX character completion at the stop-bit centre:
  - Stop bit low: set frame_err and discard the character. The FSM waits in IDLE for a high sample before accepting a new start.
  - Else, if the RX FIFO is full: set overrun_err and discard the new character; FIFO contents are kept.
  - Else: push the character. A parity mismatch still pushes the character and sets parity_err.
- RX FIFO:
  - rd_en && rdy pops; dout updates the next cycle.
  - rd_en while empty is ignored.
  - A push and a pop in the same cycle both take effect and the count is unchanged.
- Error flags:
  - err_clr clears all three flags.
  - If a set and err_clr occur in the same cycle, set wins.
- Pointers: FIFOs use N+1-bit pointers; wrap-around is implicit modulo 2^N.

Optional Feature:
- UART_LOOPBACK_EN defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the receiver input is the internal tx register, bypassing the synchroniser; the tx pin is forced high.
  - Switching loopback mid-frame is unsupported; the only requirement is recovery after one idle frame.
- Not defined: no loopback port; rx always feeds the synchroniser.

Test Plan:
- Parameters CLK_HZ=1600000, BAUD=25000 give DIV=4, so one bit = 64 clk. Push 0xA5 with 8N1 -> tx pattern is 0,1,0,1,0,0,1,0,1,1, each bit held 64 clk; tx_busy falls 640 clk after start.
- Drive an 8E1 frame of 0x3C with correct parity on rx -> rdy=1 and dout=0x3C; repeat with the parity bit flipped -> dout=0x3C and parity_err=1; err_clr -> parity_err=0.
- Send 9 frames of 0x00..0x08 with depth 8 and no reads -> the FIFO holds 0x00..0x07 and overrun_err=1; 8 pops return 0x00..0x07 in order, then rdy=0.
- Drive an rx low pulse of 3 bit-ticks (12 clk), then high -> no push, no flags. Drive a frame with the stop bit low -> frame_err=1, rdy stays 0.
- Push 9 bytes rapidly with depth 8 -> tx_full after the 8th write is accepted; the 9th is dropped with overrun_err=1; 8 frames go out back-to-back with no gap. Assert reset_n=0 mid-frame -> tx=1 the next cycle and tx_busy=0.
- With UART_LOOPBACK_EN and loopback=1, push 0x5A in 7O2 (DATA_BITS=7) -> dout=0x5A, no error flags, and the tx pin stays high throughout.

Source files
------------

// File: rtl/uart_core_if.sv
// Bus-side bundle for uart_core: the slave modport is the UART, the master modport is the CPU side.
interface uart_core_if #(
   parameter int DATA_BITS = 8
);
   // wr_en pushes din only while tx_full is low; rd_en pops only while rdy is
   // high; dout is valid whenever rdy is high and updates the cycle after a pop.
   logic [DATA_BITS-1:0] din;
   logic                 wr_en;
   logic                 tx_full;
   logic                 tx;
   logic                 tx_busy;
   logic                 rx;
   logic [DATA_BITS-1:0] dout;
   logic                 rdy;
   logic                 rd_en;
   logic                 err_clr;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;
   logic [2:0]           tx_state_dbg;
   logic [2:0]           rx_state_dbg;

   modport slave (
      input  din, wr_en, rx, rd_en, err_clr,
      output tx_full, tx, tx_busy, dout, rdy, parity_err, frame_err, overrun_err,
      output tx_state_dbg, rx_state_dbg
   );

   modport master (
      output din, wr_en, rx, rd_en, err_clr,
      input  tx_full, tx, tx_busy, dout, rdy, parity_err, frame_err, overrun_err,
      input  tx_state_dbg, rx_state_dbg
   );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART with programmable frame, 16x oversampled receiver and TX/RX FIFOs.
// Optional UART_LOOPBACK_EN adds a loopback port routing the tx register into the receiver.
module uart_core #(
   parameter int CLK_HZ        = 50000000,
   parameter int BAUD          = 115200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int TX_DEPTH_LOG2 = 3,
   parameter int RX_DEPTH_LOG2 = 3
) (
   input  logic       clk,
   input  logic       reset_n,
`ifdef UART_LOOPBACK_EN
   input  logic       loopback,
`endif
   uart_core_if.slave bus
);
   localparam int DIV   = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int DIV_W = $clog2(DIV);
   localparam int TXD   = 1 << TX_DEPTH_LOG2;
   localparam int RXD   = 1 << RX_DEPTH_LOG2;
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
   } state_t;

   logic [DIV_W-1:0] div_cnt;
   logic             tick16;

   always_ff @(posedge clk) begin
      if (!reset_n) div_cnt <= '0;
      else if (tick16) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
   end
   assign tick16 = (div_cnt == DIV_W'(DIV - 1));

   logic [DATA_BITS-1:0]   tx_mem [TXD];
   logic [TX_DEPTH_LOG2:0] tx_wptr, tx_rptr;
   logic                   tx_empty, tx_full_i, tx_push, tx_pop;

   assign tx_empty  = (tx_wptr == tx_rptr);
   assign tx_full_i = (tx_wptr[TX_DEPTH_LOG2] != tx_rptr[TX_DEPTH_LOG2]) &&
                      (tx_wptr[TX_DEPTH_LOG2-1:0] == tx_rptr[TX_DEPTH_LOG2-1:0]);
   assign tx_push   = bus.wr_en && !tx_full_i;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr[TX_DEPTH_LOG2-1:0]] <= bus.din;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      end
   end

   state_t               tx_state, tx_state_nx;
   logic [3:0]           tx_tick_cnt;
   logic [2:0]           tx_bit_cnt;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par, tx_line, tx_q, tx_busy_q, tx_bit_end;

   assign tx_bit_end = tick16 && (tx_tick_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (!reset_n) tx_state <= S_IDLE;
      else tx_state <= tx_state_nx;
   end

   always_comb begin
      tx_state_nx = tx_state;
      case (tx_state)
         S_IDLE:   if (tick16 && !tx_empty) tx_state_nx = S_START;
         S_START:  if (tx_bit_end) tx_state_nx = S_DATA;
         S_DATA:   if (tx_bit_end && tx_bit_cnt == LAST_DATA)
                      tx_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (tx_bit_end) tx_state_nx = S_STOP;
         S_STOP:   if (tx_bit_end && tx_bit_cnt == LAST_STOP)
                      tx_state_nx = tx_empty ? S_IDLE : S_START;
         default:  tx_state_nx = S_IDLE;
      endcase
   end

   // Popping at the end of the last stop bit chains frames with no idle gap.
   always_comb begin
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_state)
         S_IDLE:   tx_pop  = tick16 && !tx_empty;
         S_START:  tx_line = 1'b0;
         S_DATA:   tx_line = tx_sh[0];
         S_PARITY: tx_line = (PARITY == 1) ? ~tx_par : tx_par;
         S_STOP:   tx_pop  = tx_bit_end && (tx_bit_cnt == LAST_STOP) && !tx_empty;
         default:  tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
         tx_sh       <= '0;
         tx_par      <= 1'b0;
         tx_q        <= 1'b1;
         tx_busy_q   <= 1'b0;
      end else begin
         tx_q      <= tx_line;
         tx_busy_q <= (tx_state != S_IDLE) || !tx_empty;
         if (tx_pop) begin
            tx_sh       <= tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];
            tx_par      <= ^tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
         end else if (tick16 && tx_state != S_IDLE) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_bit_end) begin
               if (tx_state == S_DATA) tx_sh <= tx_sh >> 1;
               tx_bit_cnt <= (tx_state_nx != tx_state) ? 3'd0 : tx_bit_cnt + 3'd1;
            end
         end
      end
   end

   logic rx_s1, rx_s2, rx_in;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= bus.rx;
         rx_s2 <= rx_s1;
      end
   end

`ifdef UART_LOOPBACK_EN
   assign rx_in  = loopback ? tx_q : rx_s2;
   assign bus.tx = tx_q | loopback;
`else
   assign rx_in  = rx_s2;
   assign bus.tx = tx_q;
`endif

   state_t               rx_state, rx_state_nx;
   logic [3:0]           rx_tick_cnt;
   logic [2:0]           rx_bit_cnt;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_par_bad, rx_par_exp, rx_armed, rx_sample;
   logic                 rx_full, rx_empty, rx_push, rx_pop, rx_done;
   logic                 set_perr, set_ferr, set_rovr;

   // The seventh tick after the low is first seen lands on the start-bit centre.
   assign rx_sample  = tick16 && (rx_tick_cnt == ((rx_state == S_START) ? 4'd6 : 4'd15));
   assign rx_par_exp = (PARITY == 1) ? ~(^rx_sh) : ^rx_sh;

   always_ff @(posedge clk) begin
      if (!reset_n) rx_state <= S_IDLE;
      else rx_state <= rx_state_nx;
   end

   always_comb begin
      rx_state_nx = rx_state;
      case (rx_state)
         S_IDLE:   if (tick16 && !rx_in && rx_armed) rx_state_nx = S_START;
         S_START:  if (rx_sample) rx_state_nx = rx_in ? S_IDLE : S_DATA;
         S_DATA:   if (rx_sample && rx_bit_cnt == LAST_DATA)
                      rx_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (rx_sample) rx_state_nx = S_STOP;
         S_STOP:   if (rx_sample) rx_state_nx = S_IDLE;
         default:  rx_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      rx_done  = (rx_state == S_STOP) && rx_sample;
      rx_push  = rx_done && rx_in && !rx_full;
      set_ferr = rx_done && !rx_in;
      set_rovr = rx_done && rx_in && rx_full;
      set_perr = rx_push && rx_par_bad;
   end

   // After a framing error the line must be seen high before a new start is accepted.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_tick_cnt <= '0;
         rx_bit_cnt  <= '0;
         rx_sh       <= '0;
         rx_par_bad  <= 1'b0;
         rx_armed    <= 1'b1;
      end else if (rx_state == S_IDLE) begin
         rx_tick_cnt <= '0;
         rx_bit_cnt  <= '0;
         rx_par_bad  <= 1'b0;
         if (tick16 && rx_in) rx_armed <= 1'b1;
      end else if (tick16) begin
         rx_tick_cnt <= rx_sample ? 4'd0 : rx_tick_cnt + 4'd1;
         if (rx_sample && rx_state == S_DATA) begin
            rx_sh      <= {rx_in, rx_sh[DATA_BITS-1:1]};
            rx_bit_cnt <= rx_bit_cnt + 3'd1;
         end
         if (rx_sample && rx_state == S_PARITY) rx_par_bad <= (rx_in != rx_par_exp);
         if (set_ferr) rx_armed <= 1'b0;
      end
   end

   logic [DATA_BITS-1:0]   rx_mem [RXD];
   logic [RX_DEPTH_LOG2:0] rx_wptr, rx_rptr;

   assign rx_empty = (rx_wptr == rx_rptr);
   assign rx_full  = (rx_wptr[RX_DEPTH_LOG2] != rx_rptr[RX_DEPTH_LOG2]) &&
                     (rx_wptr[RX_DEPTH_LOG2-1:0] == rx_rptr[RX_DEPTH_LOG2-1:0]);
   assign rx_pop   = bus.rd_en && !rx_empty;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_sh;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_wptr <= '0;
         rx_rptr <= '0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      end
   end

   logic perr_q, ferr_q, oerr_q;

   // A flag being set in the same cycle as err_clr stays set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         oerr_q <= 1'b0;
      end else begin
         perr_q <= set_perr | (perr_q & ~bus.err_clr);
         ferr_q <= set_ferr | (ferr_q & ~bus.err_clr);
         oerr_q <= set_rovr | (bus.wr_en & tx_full_i) | (oerr_q & ~bus.err_clr);
      end
   end

   assign bus.tx_full      = tx_full_i;
   assign bus.tx_busy      = tx_busy_q;
   assign bus.rdy          = !rx_empty;
   assign bus.dout         = rx_empty ? '0 : rx_mem[rx_rptr[RX_DEPTH_LOG2-1:0]];
   assign bus.parity_err   = perr_q;
   assign bus.frame_err    = ferr_q;
   assign bus.overrun_err  = oerr_q;
   assign bus.tx_state_dbg = tx_state;
   assign bus.rx_state_dbg = rx_state;
endmodule
